// File: rtl/ponylink_arb_pkg.sv
// Shared constants and helpers for the PonyLink stream arbiter and its skid buffer.
package ponylink_arb_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam int unsigned SKID_DEPTH = 2;

    // Index width for n ports, never less than one bit.
    function automatic int unsigned ponylink_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ponylink_skid_buffer.sv
// Two-entry registered AXI-stream slice; the payload is an opaque WIDTH-bit vector
// (the arbiter packs {tlast, tuser, tdata} into it).
module ponylink_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_spare;
    logic             r_head_vld;
    logic             r_spare_vld;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = r_head_vld & i_m_ready;
    assign w_push = i_s_valid & ~r_spare_vld;

    // Head register drives the output; spare only fills when the head is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head      <= '0;
            r_spare     <= '0;
            r_head_vld  <= 1'b0;
            r_spare_vld <= 1'b0;
        end else if (r_spare_vld) begin
            if (w_pop) begin
                r_head      <= r_spare;
                r_spare_vld <= 1'b0;
            end
        end else if (r_head_vld) begin
            if (w_push && w_pop) begin
                r_head <= i_s_data;
            end else if (w_push) begin
                r_spare     <= i_s_data;
                r_spare_vld <= 1'b1;
            end else if (w_pop) begin
                r_head_vld <= 1'b0;
            end
        end else if (w_push) begin
            r_head     <= i_s_data;
            r_head_vld <= 1'b1;
        end
    end

    assign o_s_ready = ~r_spare_vld;
    assign o_m_data  = r_head;
    assign o_m_valid = r_head_vld;

endmodule

// File: rtl/ponylink_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the PonyLink S2M stream; the granted
// port index travels on out_tuser. Define PONYLINK_ARB_PRIO0_EN to give port 0 strict priority.
module ponylink_stream_arbiter
    import ponylink_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH    = 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             linkready,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_PORTS-1:0]             in_tvalid,
    input  logic [NUM_PORTS-1:0]             in_tlast,
    output logic [NUM_PORTS-1:0]             in_tready,
    output logic [TDATA_WIDTH-1:0]           out_tdata,
    output logic [ID_WIDTH-1:0]              out_tuser,
    output logic                             out_tvalid,
    output logic                             out_tlast,
    input  logic                             out_tready,
    output logic                             grant_valid,
    output logic [ID_WIDTH-1:0]              grant_id
);

    localparam int unsigned PAYLOAD_W = 1 + ID_WIDTH + TDATA_WIDTH;
    localparam int unsigned IDX_W     = ID_WIDTH + 1;

    if (ID_WIDTH != ponylink_clog2(NUM_PORTS)) begin : g_bad_id_width
        $error("ID_WIDTH must equal ponylink_clog2(NUM_PORTS)");
    end

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [ID_WIDTH-1:0]  r_grant_id;
    logic [ID_WIDTH-1:0]  w_grant_nxt;
    logic [ID_WIDTH-1:0]  r_last_grant;
    logic [ID_WIDTH-1:0]  w_last_nxt;
    logic                 r_prio_win;
    logic                 w_prio_nxt;

    logic [NUM_PORTS-1:0] w_rr_req;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_pick_vld;
    logic                 w_pick_prio;
    logic [ID_WIDTH-1:0]  w_pick_id;

    logic                 w_busy;
    logic                 w_skid_ready;
    logic                 w_beat_acc;
    logic [PAYLOAD_W-1:0] w_s_data;
    logic [PAYLOAD_W-1:0] w_m_data;

    // Round-robin candidate: first requester after last_grant, wrapping modulo NUM_PORTS.
    always_comb begin : arb_pick
        w_pick_vld  = 1'b0;
        w_pick_prio = 1'b0;
        w_pick_id   = '0;
        w_idx       = '0;
`ifdef PONYLINK_ARB_PRIO0_EN
        w_rr_req    = {in_tvalid[NUM_PORTS-1:1], 1'b0};
`else
        w_rr_req    = in_tvalid;
`endif
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            w_idx = {1'b0, r_last_grant} + IDX_W'(i);
            if (w_idx >= IDX_W'(NUM_PORTS)) begin
                w_idx = w_idx - IDX_W'(NUM_PORTS);
            end
            if (!w_pick_vld && w_rr_req[ID_WIDTH'(w_idx)]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = ID_WIDTH'(w_idx);
            end
        end
`ifdef PONYLINK_ARB_PRIO0_EN
        if (in_tvalid[0]) begin
            w_pick_vld  = 1'b1;
            w_pick_prio = 1'b1;
            w_pick_id   = '0;
        end
`endif
    end

    assign w_busy     = (r_state == ARB_BUSY);
    assign w_beat_acc = w_busy & in_tvalid[r_grant_id] & w_skid_ready;

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_grant;
        w_prio_nxt  = r_prio_win;
        case (r_state)
            ARB_IDLE: begin
                if (linkready && w_pick_vld) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_pick_id;
                    w_prio_nxt  = w_pick_prio;
                end
            end
            ARB_BUSY: begin
                // Grant is held until tlast, regardless of linkready or tvalid gaps.
                if (w_beat_acc && in_tlast[r_grant_id]) begin
                    w_state_nxt = ARB_IDLE;
                    if (!r_prio_win) begin
                        w_last_nxt = r_grant_id;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ARB_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_WIDTH'(NUM_PORTS - 1);
            r_prio_win   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_prio_win   <= w_prio_nxt;
        end
    end

    always_comb begin : ready_decode
        in_tready = '0;
        if (w_busy) begin
            in_tready[r_grant_id] = w_skid_ready;
        end
    end

    assign w_s_data = {in_tlast[r_grant_id], r_grant_id,
                       in_tdata[r_grant_id*TDATA_WIDTH +: TDATA_WIDTH]};

    ponylink_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .i_s_data  (w_s_data),
        .i_s_valid (w_busy & in_tvalid[r_grant_id]),
        .o_s_ready (w_skid_ready),
        .o_m_data  (w_m_data),
        .o_m_valid (out_tvalid),
        .i_m_ready (out_tready)
    );

    assign out_tlast   = w_m_data[PAYLOAD_W-1];
    assign out_tuser   = w_m_data[TDATA_WIDTH +: ID_WIDTH];
    assign out_tdata   = w_m_data[TDATA_WIDTH-1:0];
    assign grant_valid = w_busy;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_ponylink_stream_arbiter.sv
// Scoreboard bench for ponylink_stream_arbiter: per-port packet sources, a packet-level
// round-robin reference model, and a monitor that checks every output beat.
module tb_ponylink_stream_arbiter;

    localparam int NP   = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int MAXB = 128;
    localparam int MAXP = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              linkready;
    logic [NP*W-1:0]   in_tdata;
    logic [NP-1:0]     in_tvalid;
    logic [NP-1:0]     in_tlast;
    logic [NP-1:0]     in_tready;
    logic [W-1:0]      out_tdata;
    logic [IDW-1:0]    out_tuser;
    logic              out_tvalid;
    logic              out_tlast;
    logic              out_tready;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;

    ponylink_stream_arbiter #(
        .NUM_PORTS   (NP),
        .TDATA_WIDTH (W),
        .ID_WIDTH    (IDW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .linkready   (linkready),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tlast    (in_tlast),
        .in_tready   (in_tready),
        .out_tdata   (out_tdata),
        .out_tuser   (out_tuser),
        .out_tvalid  (out_tvalid),
        .out_tlast   (out_tlast),
        .out_tready  (out_tready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Source storage: beats are {last, data}
    logic [W:0]      src_mem [NP][MAXB];
    int              src_n   [NP];
    int              src_ptr [NP];
    int              pk_len  [NP][MAXP];
    int              pk_n    [NP];
    int              hold    [NP];
    bit              mid     [NP];
    logic [NP-1:0]   hs = '0;
    int              gap_pct = 0;
    int              rdy_mode = 0;
    int              pat_i = 0;
    logic [3:0]      pat = 4'b1001;
    logic [W:0]      drv_b;

    logic [W+IDW:0]  exp_q[$];
    logic [W+IDW:0]  got;
    logic [W+IDW:0]  prev;
    logic [W+IDW:0]  exp_v;
    bit              prev_stall = 0;
    int              hs_cnt = 0;
    int              first_hs = -1;
    int              last_hs = -1;
    int              first_vld = -1;
    int              last_g = NP - 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            src_n[p] = 0; src_ptr[p] = 0; pk_n[p] = 0; hold[p] = 0; mid[p] = 1'b0;
        end
    endtask

    task automatic add_pkt(input int p, input int len, input logic [W-1:0] d0, input bit rnd);
        for (int b = 0; b < len; b++) begin
            src_mem[p][src_n[p]] = {(b == len - 1), (rnd ? W'($urandom) : d0 + W'(b))};
            src_n[p]++;
        end
        pk_len[p][pk_n[p]] = len;
        pk_n[p]++;
    endtask

    function automatic bit srcs_empty();
        bit e;
        e = 1'b1;
        for (int p = 0; p < NP; p++) if (src_ptr[p] != src_n[p]) e = 1'b0;
        return e;
    endfunction

    // Reference: every port with pending packets is requesting at each decision, so the
    // packet order is plain round-robin over non-empty ports (port 0 first when prioritised).
    task automatic run_model();
        int k[NP];
        int off[NP];
        int g;
        int c;
        bit any;
        logic [W:0] bt;
        for (int p = 0; p < NP; p++) begin k[p] = 0; off[p] = 0; end
        forever begin
            any = 1'b0;
            for (int p = 0; p < NP; p++) if (k[p] < pk_n[p]) any = 1'b1;
            if (!any) break;
            g = -1;
`ifdef PONYLINK_ARB_PRIO0_EN
            if (k[0] < pk_n[0]) g = 0;
`endif
            for (int i = 1; i <= NP; i++) begin
                c = (last_g + i) % NP;
`ifdef PONYLINK_ARB_PRIO0_EN
                if (g < 0 && c != 0 && k[c] < pk_n[c]) g = c;
`else
                if (g < 0 && k[c] < pk_n[c]) g = c;
`endif
            end
            for (int b = 0; b < pk_len[g][k[g]]; b++) begin
                bt = src_mem[g][off[g]];
                exp_q.push_back({bt[W], IDW'(g), bt[W-1:0]});
                off[g]++;
            end
            k[g]++;
`ifdef PONYLINK_ARB_PRIO0_EN
            if (g != 0) last_g = g;
`else
            last_g = g;
`endif
        end
    endtask

    task automatic wait_drain(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_tvalid && !grant_valid && srcs_empty();
        end
        check({nm, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        clear_src();
        exp_q.delete();
        last_g = NP - 1;
        resetn = 1'b1;
    endtask

    // Source and sink driver: updates just after each rising edge.
    initial begin
        in_tvalid = '0; in_tlast = '0; in_tdata = '0; out_tready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p]) begin
                    drv_b = src_mem[p][src_ptr[p]];
                    src_ptr[p]++;
                    mid[p] = !drv_b[W];
                    if (mid[p] && gap_pct > 0 && $urandom_range(99) < gap_pct)
                        hold[p] = $urandom_range(2, 1);
                end
                if (hold[p] > 0) begin
                    hold[p]--;
                    in_tvalid[p] = 1'b0;
                end else if (src_ptr[p] < src_n[p]) begin
                    drv_b = src_mem[p][src_ptr[p]];
                    in_tdata[p*W +: W] = drv_b[W-1:0];
                    in_tlast[p] = drv_b[W];
                    in_tvalid[p] = 1'b1;
                end else begin
                    in_tvalid[p] = 1'b0;
                    in_tlast[p] = 1'b0;
                end
            end
            case (rdy_mode)
                0: out_tready = 1'b1;
                1: out_tready = ($urandom_range(99) < 65);
                default: begin out_tready = pat[pat_i % 4]; pat_i++; end
            endcase
        end
    end

    // Monitor: scoreboard pop on each output handshake plus protocol checks.
    initial begin
        forever begin
            @(negedge clk);
            hs = in_tvalid & in_tready;
            if (resetn) begin
                got = {out_tlast, out_tuser, out_tdata};
                if (prev_stall) check("stall_hold", {out_tvalid, got}, {1'b1, prev});
                if (out_tvalid && first_vld < 0) first_vld = cyc;
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none", got);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("beat", got, exp_v);
                    end
                    hs_cnt++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
                prev_stall = out_tvalid && !out_tready;
                prev = got;
                check("grant_id_range", 64'(grant_id < NP), 64'd1);
                check("tready_onehot0", 64'($countones(in_tready) <= 1), 64'd1);
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int load_cyc;
        int base;
        bit seen;
        resetn = 1'b0; linkready = 1'b0;
        clear_src();
        repeat (2) @(negedge clk);
        check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_in_tready", 64'(in_tready), 64'd0);
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_out_bus", {out_tlast, out_tuser, out_tdata}, 64'd0);
        resetn = 1'b1; linkready = 1'b1;

        // Single 3-beat packet from port 2 and its latency
        @(negedge clk);
        first_vld = -1; load_cyc = cyc;
        add_pkt(2, 3, 8'hA1, 1'b0);
        run_model();
        wait_drain("pkt_p2");
        check("latency", 64'(first_vld - (load_cyc + 1)), 64'd2);

        // Three continuous requesters: order and one bubble per packet
        do_reset();
        first_hs = -1;
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 2, 8'h00 + 8'(r * 16), 1'b0);
            add_pkt(1, 2, 8'h40 + 8'(r * 16), 1'b0);
            add_pkt(3, 2, 8'hC0 + 8'(r * 16), 1'b0);
        end
        run_model();
        wait_drain("rr3");
        check("b2b_span", 64'(last_hs - first_hs), 64'd16);

        // Output back-pressure pattern 1,0,0,1
        @(negedge clk);
        clear_src();
        rdy_mode = 2; pat_i = 0;
        add_pkt(1, 4, 8'h51, 1'b0);
        run_model();
        wait_drain("stall");
        rdy_mode = 0;

        // linkready gating, then drop mid-packet
        @(negedge clk);
        clear_src();
        linkready = 1'b0;
        add_pkt(0, 4, 8'h70, 1'b0);
        run_model();
        repeat (10) begin
            @(negedge clk);
            check("link_down_tready", 64'(in_tready), 64'd0);
        end
        linkready = 1'b1;
        @(negedge clk);
        check("link_up_grant_valid", 64'(grant_valid), 64'd1);
        check("link_up_grant_id", 64'(grant_id), 64'd0);
        check("link_up_tready", 64'(in_tready), 64'd1);
        @(negedge clk);
        linkready = 1'b0;
        wait_drain("link_drop");
        linkready = 1'b1;

        // Async reset mid-packet
        @(negedge clk);
        clear_src();
        add_pkt(0, 4, 8'hE0, 1'b0);
        run_model();
        base = hs_cnt;
        for (int i = 0; i < 50 && hs_cnt < base + 2; i++) @(negedge clk);
        check("mid_pkt_progress", 64'(hs_cnt >= base + 2), 64'd1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_outs",
              {in_tready, out_tvalid, out_tlast, out_tuser, out_tdata, grant_valid, grant_id}, 64'd0);
        @(negedge clk);
        clear_src();
        exp_q.delete();
        last_g = NP - 1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        add_pkt(2, 2, 8'h2A, 1'b0);
        add_pkt(0, 2, 8'h0A, 1'b0);
        run_model();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = grant_valid;
        end
        check("post_rst_first_grant", {63'(seen ? 0 : 1), 1'b0} | 64'(grant_id), 64'd0);
        wait_drain("post_rst");

`ifdef PONYLINK_ARB_PRIO0_EN
        // Port 0 strict priority, then round-robin between 1 and 2
        @(negedge clk);
        clear_src();
        for (int r = 0; r < 3; r++) add_pkt(0, 2, 8'h10 + 8'(r * 4), 1'b0);
        for (int r = 0; r < 2; r++) begin
            add_pkt(1, 2, 8'h60 + 8'(r * 4), 1'b0);
            add_pkt(2, 3, 8'h90 + 8'(r * 4), 1'b0);
        end
        run_model();
        wait_drain("prio0");
`endif

        // Randomised rounds: random packets, tvalid gaps and out_tready
        rdy_mode = 1; gap_pct = 30;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            clear_src();
            for (int p = 0; p < NP; p++) begin
                int n;
                n = $urandom_range(3);
                for (int j = 0; j < n; j++) add_pkt(p, $urandom_range(5, 1), 8'h00, 1'b1);
            end
            run_model();
            wait_drain("random");
        end
        rdy_mode = 0; gap_pct = 0;

        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
